// File: rtl/sdr_test_pkg.sv
// Shared types and constants for the sdr_as_ram write/read-back checker.
package sdr_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_NADDR = 2'd3
  } pat_mode_e;

  // Galois mask for x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int unsigned ERR_W     = 16;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sdr_pattern_gen.sv
// Produces the data word for a given address offset in the selected pattern mode.
module sdr_pattern_gen
  import sdr_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned ADDR_BASE  = 0,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reload,
  input  logic                  step,
  input  pat_mode_e             mode,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0] word_c
);

  logic [31:0]           lfsr_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rep;

  assign addr = ADDR_WIDTH'(ADDR_BASE) + offset;

  // LFSR word is replicated / truncated to the data width
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rep
    assign rep[i] = lfsr_q[i % 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (reload) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    word_c = '0;
    unique case (mode)
      PAT_ADDR:  word_c = DATA_WIDTH'(addr);
      PAT_LFSR:  word_c = rep;
      PAT_WALK:  word_c = DATA_WIDTH'(1) << (32'(offset) % DATA_WIDTH);
      PAT_NADDR: word_c = ~DATA_WIDTH'(addr);
      default:   word_c = '0;
    endcase
  end

endmodule

// File: rtl/sdr_wrrd_checker.sv
// Write/read-back traffic generator and checker for the sdr_as_ram app port:
// fills an address window with a pattern, reads it back in order and compares.
module sdr_wrrd_checker
  import sdr_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 21,
  parameter int unsigned DM_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned ADDR_BASE       = 0,
  parameter int unsigned ADDR_LEN        = 1024,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT         = 4096,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [1:0]            Mode,
  input  logic                  Loop,
  input  logic                  Sdr_init_done,
  input  logic                  Sdr_init_ref_vld,
  input  logic                  Sdr_busy,
  output logic                  App_wr_en,
  output logic [ADDR_WIDTH-1:0] App_wr_addr,
  output logic [DM_WIDTH-1:0]   App_wr_dm,
  output logic [DATA_WIDTH-1:0] App_wr_din,
  output logic                  App_rd_en,
  output logic [ADDR_WIDTH-1:0] App_rd_addr,
  input  logic                  Sdr_rd_en,
  input  logic [DATA_WIDTH-1:0] Sdr_rd_dout,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Check_ok,
  output logic [ERR_W-1:0]      Err_cnt,
  output logic [ADDR_WIDTH-1:0] First_err_addr,
  output logic                  Timeout,
  output logic [15:0]           Pass_cnt
);

  localparam int unsigned CNT_W = $clog2(ADDR_LEN + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(ADDR_BASE);

  state_e                state_q, state_d;
  pat_mode_e             mode_q;
  logic [CNT_W-1:0]      wr_cnt_q, rd_cnt_q, chk_cnt_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic [TMR_W-1:0]      timer_q;
  logic                  err_seen_q;
  logic [DATA_WIDTH-1:0] wr_word_c, exp_word_c;

  logic iss_ok_c, start_accept_c, start_pass_c, wr_issue_c, rd_issue_c;
  logic timeout_hit_c, enter_done_c, beat_c, stray_c, mismatch_c, err_inc_c;

  assign iss_ok_c   = Sdr_init_done & ~Sdr_init_ref_vld & ~Sdr_busy;
  assign beat_c     = Sdr_rd_en & (outstanding_q != '0);
  assign stray_c    = Sdr_rd_en & (outstanding_q == '0);
  assign mismatch_c = beat_c & (Sdr_rd_dout != exp_word_c);
  assign err_inc_c  = mismatch_c | stray_c;
  assign enter_done_c = (state_d == ST_DONE) && (state_q != ST_DONE);
  assign App_wr_dm  = '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (Start) state_d = ST_WAIT_INIT;
      ST_WAIT_INIT: if (Sdr_init_done) state_d = ST_WRITE;
      ST_WRITE:     if (wr_cnt_q == CNT_W'(ADDR_LEN)) state_d = ST_READ;
      ST_READ:      if (rd_cnt_q == CNT_W'(ADDR_LEN)) state_d = ST_DRAIN;
      ST_DRAIN:     if ((outstanding_q == '0) || timeout_hit_c) state_d = ST_DONE;
      ST_DONE:      if (Start || Loop) state_d = ST_WAIT_INIT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes driving the registered outputs and datapath
  always_comb begin
    start_accept_c = 1'b0;
    start_pass_c   = 1'b0;
    wr_issue_c     = 1'b0;
    rd_issue_c     = 1'b0;
    timeout_hit_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        start_accept_c = Start;
        start_pass_c   = Start;
      end
      ST_DONE: begin
        start_accept_c = Start;
        start_pass_c   = Start | Loop;
      end
      ST_WRITE: wr_issue_c = iss_ok_c && (wr_cnt_q < CNT_W'(ADDR_LEN));
      ST_READ:  rd_issue_c = iss_ok_c && (rd_cnt_q < CNT_W'(ADDR_LEN)) &&
                             (outstanding_q < OUT_W'(MAX_OUTSTANDING));
      ST_DRAIN: timeout_hit_c = (outstanding_q != '0) && !Sdr_rd_en &&
                                (timer_q == TMR_W'(TIMEOUT - 1));
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      App_wr_en   <= 1'b0;
      App_wr_addr <= '0;
      App_wr_din  <= '0;
      App_rd_en   <= 1'b0;
      App_rd_addr <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass_cnt    <= '0;
    end else begin
      App_wr_en <= wr_issue_c;
      App_rd_en <= rd_issue_c;
      if (wr_issue_c) begin
        App_wr_addr <= BASE_ADDR + ADDR_WIDTH'(wr_cnt_q);
        App_wr_din  <= wr_word_c;
      end
      if (rd_issue_c) App_rd_addr <= BASE_ADDR + ADDR_WIDTH'(rd_cnt_q);
      Busy <= (state_d inside {ST_WAIT_INIT, ST_WRITE, ST_READ, ST_DRAIN});
      Done <= (state_d == ST_DONE);
      if (enter_done_c) Pass_cnt <= Pass_cnt + 16'd1;
    end
  end

  // Issue / compare counters; outstanding holds when a read and a beat coincide
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      chk_cnt_q     <= '0;
      outstanding_q <= '0;
      timer_q       <= '0;
    end else begin
      if (start_pass_c) begin
        wr_cnt_q      <= '0;
        rd_cnt_q      <= '0;
        chk_cnt_q     <= '0;
        outstanding_q <= '0;
      end else begin
        if (wr_issue_c) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        if (rd_issue_c) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        if (beat_c)     chk_cnt_q <= chk_cnt_q + CNT_W'(1);
        if (rd_issue_c && !beat_c)      outstanding_q <= outstanding_q + OUT_W'(1);
        else if (!rd_issue_c && beat_c) outstanding_q <= outstanding_q - OUT_W'(1);
      end
      if ((state_q == ST_DRAIN) && !Sdr_rd_en) timer_q <= timer_q + TMR_W'(1);
      else                                     timer_q <= '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q         <= PAT_ADDR;
      Err_cnt        <= '0;
      First_err_addr <= '0;
      err_seen_q     <= 1'b0;
      Timeout        <= 1'b0;
      Check_ok       <= 1'b0;
    end else begin
      if (start_accept_c) mode_q <= pat_mode_e'(Mode);
      if (start_pass_c) begin
        Err_cnt        <= '0;
        First_err_addr <= '0;
        err_seen_q     <= 1'b0;
        Timeout        <= 1'b0;
        Check_ok       <= 1'b0;
      end else begin
        if (err_inc_c && (Err_cnt != '1)) Err_cnt <= Err_cnt + ERR_W'(1);
        if (mismatch_c && !err_seen_q) begin
          err_seen_q     <= 1'b1;
          First_err_addr <= BASE_ADDR + ADDR_WIDTH'(chk_cnt_q);
        end
        if (timeout_hit_c) Timeout <= 1'b1;
        if (enter_done_c) Check_ok <= (Err_cnt == '0) && !err_inc_c && !timeout_hit_c;
      end
    end
  end

  sdr_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BASE  (ADDR_BASE),
    .LFSR_SEED  (LFSR_SEED)
  ) u_wr_pat (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .reload (state_q == ST_WAIT_INIT),
    .step   (wr_issue_c),
    .mode   (mode_q),
    .offset (ADDR_WIDTH'(wr_cnt_q)),
    .word_c (wr_word_c)
  );

  sdr_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BASE  (ADDR_BASE),
    .LFSR_SEED  (LFSR_SEED)
  ) u_exp_pat (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .reload ((state_q == ST_WAIT_INIT) || (state_q == ST_WRITE)),
    .step   (beat_c),
    .mode   (mode_q),
    .offset (ADDR_WIDTH'(chk_cnt_q)),
    .word_c (exp_word_c)
  );

endmodule

// File: tb/tb_sdr_wrrd_checker.sv
// Directed bench for sdr_wrrd_checker with a latency-configurable memory model.
module tb_sdr_wrrd_checker;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 21;
  localparam int unsigned BASE = 100;
  localparam int unsigned LEN  = 16;
  localparam int unsigned MAXO = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;

  logic          Clk = 1'b0;
  logic          Rst_n, Start, Loop, Sdr_init_done, Sdr_init_ref_vld, Sdr_busy;
  logic [1:0]    Mode;
  logic          App_wr_en, App_rd_en, Sdr_rd_en;
  logic [AW-1:0] App_wr_addr, App_rd_addr, First_err_addr;
  logic [3:0]    App_wr_dm;
  logic [DW-1:0] App_wr_din, Sdr_rd_dout;
  logic          Busy, Done, Check_ok, Timeout;
  logic [15:0]   Err_cnt, Pass_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0, lat = 3, out_cnt = 0, max_out = 0, wr_seen = 0, rd_seen = 0;
  bit corrupt = 0, drop = 0, rand_busy = 0, prev_iss = 0;
  logic [DW-1:0] mem [0:LEN-1];
  wr_t           wr_exp_q[$];
  logic [AW-1:0] rd_exp_q[$];
  rsp_t          rsp_q[$];

  always #5 Clk = ~Clk;

  sdr_wrrd_checker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_BASE(BASE), .ADDR_LEN(LEN),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT(4096), .LFSR_SEED(SEED)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mode(Mode), .Loop(Loop),
    .Sdr_init_done(Sdr_init_done), .Sdr_init_ref_vld(Sdr_init_ref_vld),
    .Sdr_busy(Sdr_busy), .App_wr_en(App_wr_en), .App_wr_addr(App_wr_addr),
    .App_wr_dm(App_wr_dm), .App_wr_din(App_wr_din), .App_rd_en(App_rd_en),
    .App_rd_addr(App_rd_addr), .Sdr_rd_en(Sdr_rd_en), .Sdr_rd_dout(Sdr_rd_dout),
    .Busy(Busy), .Done(Done), .Check_ok(Check_ok), .Err_cnt(Err_cnt),
    .First_err_addr(First_err_addr), .Timeout(Timeout), .Pass_cnt(Pass_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) begin
      n[31] = ~n[31]; n[21] = ~n[21]; n[1] = ~n[1]; n[0] = ~n[0];
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] pat(input int m, input int k, input logic [31:0] s);
    logic [AW-1:0] a;
    a = AW'(BASE + k);
    case (m)
      0:       return DW'(a);
      1:       return s;
      2:       return 32'h1 << (k % 32);
      default: return ~DW'(a);
    endcase
  endfunction

  task automatic push_pass(input int m);
    logic [31:0] s;
    s = SEED;
    for (int k = 0; k < int'(LEN); k++) begin
      wr_exp_q.push_back('{AW'(BASE + k), pat(m, k, s)});
      rd_exp_q.push_back(AW'(BASE + k));
      s = lfsr_step(s);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic start_pass(input logic [1:0] m);
    wr_seen = 0; rd_seen = 0; max_out = 0;
    Mode = m; Start = 1'b1;
    step();
    Start = 1'b0; Mode = 2'd0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < budget) begin step(); n++; end
    chk("done_in_time", 32'(Done), 1);
  endtask

  task automatic chk_drained();
    chk("wr_q_drained", 32'(wr_exp_q.size()), 0);
    chk("rd_q_drained", 32'(rd_exp_q.size()), 0);
  endtask

  // Memory model, busy generator and request-protocol checks, all on the falling edge
  initial begin
    wr_t  w;
    rsp_t r;
    int   off;
    logic [DW-1:0] d;
    Sdr_busy = 1'b0; Sdr_rd_en = 1'b0; Sdr_rd_dout = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst_n) begin
        wr_exp_q.delete(); rd_exp_q.delete(); rsp_q.delete();
        Sdr_rd_en = 1'b0; Sdr_busy = 1'b0; out_cnt = 0; prev_iss = 0;
        continue;
      end
      if (App_wr_en || App_rd_en) begin
        chk("issue_while_blocked", 32'(prev_iss), 1);
        chk("wr_rd_exclusive", 32'(App_wr_en & App_rd_en), 0);
      end
      if (App_wr_en) begin
        wr_seen++;
        chk("wr_expected", 32'(wr_exp_q.size() > 0), 1);
        if (wr_exp_q.size() > 0) begin
          w = wr_exp_q.pop_front();
          chk("wr_addr", 32'(App_wr_addr), 32'(w.addr));
          chk("wr_data", App_wr_din, w.data);
        end
        off = int'(App_wr_addr) - int'(BASE);
        if (off >= 0 && off < int'(LEN)) mem[off] = App_wr_din;
      end
      if (App_rd_en) begin
        rd_seen++;
        chk("rd_expected", 32'(rd_exp_q.size() > 0), 1);
        if (rd_exp_q.size() > 0) chk("rd_addr", 32'(App_rd_addr), 32'(rd_exp_q.pop_front()));
        off = int'(App_rd_addr) - int'(BASE);
        d = (off >= 0 && off < int'(LEN)) ? mem[off] : '0;
        if (corrupt && (off == 7 || off == 9)) d = d ^ 32'h20;
        if (!(drop && off == int'(LEN) - 1)) begin
          rsp_q.push_back('{cyc + lat, d});
          out_cnt++;
          if (out_cnt > max_out) max_out = out_cnt;
        end
      end
      Sdr_rd_en = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        Sdr_rd_en = 1'b1; Sdr_rd_dout = r.data; out_cnt--;
      end
      Sdr_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_iss = Sdr_init_done & ~Sdr_init_ref_vld & ~Sdr_busy;
    end
  end

  initial begin
    int n, snap;
    Rst_n = 1'b0; Start = 1'b0; Mode = 2'd0; Loop = 1'b0;
    Sdr_init_done = 1'b0; Sdr_init_ref_vld = 1'b0;
    repeat (3) step();
    chk("rst_wr_en", 32'(App_wr_en), 0);
    chk("rst_rd_en", 32'(App_rd_en), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_check_ok", 32'(Check_ok), 0);
    chk("rst_pass_cnt", 32'(Pass_cnt), 0);
    chk("rst_wr_dm", 32'(App_wr_dm), 0);
    Rst_n = 1'b1; Sdr_init_done = 1'b1;
    repeat (2) step();

    // Mode 0, ideal memory
    lat = 3; push_pass(0); start_pass(2'd0); wait_done(2000);
    chk("p1_check_ok", 32'(Check_ok), 1);
    chk("p1_err_cnt", 32'(Err_cnt), 0);
    chk("p1_pass_cnt", 32'(Pass_cnt), 1);
    chk("p1_timeout", 32'(Timeout), 0);
    chk("p1_busy", 32'(Busy), 0);
    chk("p1_writes", 32'(wr_seen), LEN);
    chk("p1_reads", 32'(rd_seen), LEN);
    chk("p1_max_out_le", 32'(max_out <= int'(MAXO)), 1);
    chk_drained();

    // Mode 1, bit 5 corrupted at offsets 7 and 9
    corrupt = 1; push_pass(1); start_pass(2'd1); wait_done(2000); corrupt = 0;
    chk("p2_err_cnt", 32'(Err_cnt), 2);
    chk("p2_first_err", 32'(First_err_addr), BASE + 7);
    chk("p2_check_ok", 32'(Check_ok), 0);
    chk("p2_pass_cnt", 32'(Pass_cnt), 2);
    chk_drained();

    // Mode 3, random busy, long latency, outstanding limit
    rand_busy = 1; lat = 20; push_pass(3); start_pass(2'd3); wait_done(3000);
    rand_busy = 0; lat = 3;
    chk("p3_check_ok", 32'(Check_ok), 1);
    chk("p3_err_cnt", 32'(Err_cnt), 0);
    chk("p3_max_out", 32'(max_out), MAXO);
    chk("p3_pass_cnt", 32'(Pass_cnt), 3);
    chk_drained();

    // Dropped last response -> read-back timeout
    drop = 1; push_pass(0); start_pass(2'd0); wait_done(6000); drop = 0;
    chk("p4_timeout", 32'(Timeout), 1);
    chk("p4_check_ok", 32'(Check_ok), 0);
    chk("p4_err_cnt", 32'(Err_cnt), 0);
    chk("p4_pass_cnt", 32'(Pass_cnt), 4);
    chk_drained();

    // Loop mode, walking one: three passes from a single Start
    for (int p = 0; p < 3; p++) push_pass(2);
    Loop = 1'b1; start_pass(2'd2);
    n = 0;
    while (Pass_cnt !== 16'd7 && n < 3000) begin step(); n++; end
    Loop = 1'b0;
    chk("loop_pass_cnt", 32'(Pass_cnt), 7);
    chk("loop_check_ok", 32'(Check_ok), 1);
    chk("loop_done", 32'(Done), 1);
    step();
    chk("loop_stopped_done", 32'(Done), 1);
    chk_drained();

    // Reset in the middle of the write phase
    push_pass(0); start_pass(2'd0);
    n = 0;
    while (wr_seen < 3 && n < 200) begin step(); n++; end
    chk("mid_write_reached", 32'(wr_seen >= 3), 1);
    Rst_n = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(App_wr_en), 0);
    chk("mrst_busy", 32'(Busy), 0);
    chk("mrst_pass_cnt", 32'(Pass_cnt), 0);
    chk("mrst_done", 32'(Done), 0);
    chk("mrst_check_ok", 32'(Check_ok), 0);
    repeat (3) step();
    Rst_n = 1'b1;
    repeat (2) step();

    // Init stall after Start, refresh pulse during READ
    Sdr_init_done = 1'b0;
    push_pass(1); start_pass(2'd1);
    repeat (100) step();
    chk("stall_no_writes", 32'(wr_seen), 0);
    chk("stall_busy", 32'(Busy), 1);
    Sdr_init_done = 1'b1;
    n = 0;
    while (rd_seen < 2 && n < 500) begin step(); n++; end
    chk("reads_started", 32'(rd_seen >= 2), 1);
    Sdr_init_ref_vld = 1'b1;
    repeat (2) step();
    snap = rd_seen;
    repeat (6) step();
    chk("ref_blocks_reads", 32'(rd_seen), 32'(snap));
    Sdr_init_ref_vld = 1'b0;
    wait_done(2000);
    chk("p7_check_ok", 32'(Check_ok), 1);
    chk("p7_err_cnt", 32'(Err_cnt), 0);
    chk("p7_pass_cnt", 32'(Pass_cnt), 1);
    chk("p7_reads", 32'(rd_seen), LEN);
    chk_drained();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_wrrd_checker.md
Name: sdr_wrrd_checker

Overview:
- Parametrised, mode-selectable write/read-back traffic generator and checker for the sdr_as_ram application port.
- Fills a configurable address window with a selectable data pattern, then reads the window back in address order and compares each returned word against a regenerated expected word.
- Reports pass/fail, error count and first failing address. Optionally loops forever for soak testing.
- Sits between the board top and sdr_as_ram, in the place used by the fixed-pattern app-level tester.

Parameters:
- DATA_WIDTH, 32: App data width; a multiple of 8.
- ADDR_WIDTH, 21: App word-address width.
- DM_WIDTH, DATA_WIDTH/8: byte-mask width.
- ADDR_BASE, 0: first word address tested.
- ADDR_LEN, 1024: number of words tested; ADDR_BASE+ADDR_LEN <= 2^ADDR_WIDTH.
- MAX_OUTSTANDING, 8: maximum reads issued but not yet returned; power of 2.
- TIMEOUT, 4096: cycles without Sdr_rd_en in DRAIN before abort.
- LFSR_SEED, 32'hACE1_2468: LFSR start value; must be nonzero.

Ports:
- Clk  in  1  system clock, same clock as sdr_as_ram Sdr_clk
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse; starts a pass when in IDLE or DONE
- Mode  in  2  pattern select, sampled at Start
- Loop  in  1  restart automatically after each pass
- Sdr_init_done  in  1  controller initialisation complete
- Sdr_init_ref_vld  in  1  controller refresh/init busy; no requests may be issued
- Sdr_busy  in  1  controller cannot accept a request this cycle
- App_wr_en  out  1  write request, one word per cycle
- App_wr_addr  out  ADDR_WIDTH  write address
- App_wr_dm  out  DM_WIDTH  write mask; always 0, all bytes enabled
- App_wr_din  out  DATA_WIDTH  write data
- App_rd_en  out  1  read request
- App_rd_addr  out  ADDR_WIDTH  read address
- Sdr_rd_en  in  1  read data valid; returns in request order
- Sdr_rd_dout  in  DATA_WIDTH  read data
- Busy  out  1  pass in progress
- Done  out  1  pass finished; held until next Start
- Check_ok  out  1  Done and no errors and no timeout
- Err_cnt  out  16  mismatch count, saturating at 16'hFFFF
- First_err_addr  out  ADDR_WIDTH  address of first mismatch
- Timeout  out  1  read-back stalled
- Pass_cnt  out  16  completed passes, wrapping

Behaviour:
- Reset values: all outputs 0. State returns to IDLE asynchronously; the LFSR reloads LFSR_SEED.
- Issue enable: iss_ok = Sdr_init_done & !Sdr_init_ref_vld & !Sdr_busy. Requests are registered outputs; a request is counted as accepted in every cycle its enable is high.
- Write and read are never asserted in the same cycle.
- Patterns are a function of the address offset k = addr-ADDR_BASE:
  - Mode 0: zero-extended address.
  - Mode 1: 32-bit Galois LFSR (x^32+x^22+x^2+x+1), advanced once per word, value replicated/truncated to DATA_WIDTH. Write and check use separate LFSR copies, both reloaded at phase start.
  - Mode 2: walking one, 1<<(k mod DATA_WIDTH).
  - Mode 3: inverted address.
- FSM states: IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE.
  - IDLE/DONE + Start: latch Mode, clear Err_cnt, Timeout, First_err_addr and Check_ok, then go to WAIT_INIT. Start is ignored in any other state.
  - WAIT_INIT -> WRITE when Sdr_init_done=1.
  - WRITE: issue one word per iss_ok cycle. After ADDR_LEN words -> READ.
  - READ: issue reads while iss_ok and outstanding < MAX_OUTSTANDING. After ADDR_LEN issued -> DRAIN.
  - DRAIN -> DONE when outstanding = 0. A timer counts cycles without Sdr_rd_en; at TIMEOUT, set Timeout and go to DONE.
  - DONE: Done=1, Pass_cnt++. Check_ok = (Err_cnt==0 & !Timeout). If Loop=1, go to WAIT_INIT after one cycle.
- Outstanding counter: +1 on an issued read, -1 on Sdr_rd_en, unchanged when both happen in the same cycle. It must never underflow.
- Compare: each Sdr_rd_en beat compares against the expected word, then the expected address advances.
  - On mismatch, Err_cnt increments, saturating.
  - First_err_addr is captured only on the first mismatch.
  - Sdr_rd_en while outstanding=0 counts as one error and is not compared.
- Sdr_init_done or Sdr_init_ref_vld changing mid-pass only stalls issue; it does not abort the pass.
- Asserting Rst_n mid-pass aborts immediately and drops all request enables; outstanding reads are discarded.

Decomposition:
- Shared package sdr_test_pkg holds: the state encoding, the Mode constants (PAT_ADDR, PAT_LFSR, PAT_WALK, PAT_NADDR), the LFSR polynomial and an error-count width constant.
- One sub-module, sdr_pattern_gen: given offset, mode, and step/reload controls, it produces a DATA_WIDTH word.
- Two instances of sdr_pattern_gen: one for the write side, one for the expected side.

Test Plan:
- Mode 0, ADDR_LEN=16, ideal memory model with 3-cycle read latency, Start -> 16 writes with data = address, 16 reads, Done=1, Check_ok=1, Err_cnt=0, Pass_cnt=1.
- Mode 1, memory corrupts bit 5 at offset 7 and offset 9 -> Err_cnt=2, First_err_addr=ADDR_BASE+7, Check_ok=0.
- Sdr_busy toggling randomly at 50% and read latency of 20 cycles with MAX_OUTSTANDING=4 -> outstanding never exceeds 4, no request is issued while busy, Check_ok=1.
- Memory model drops the last read response -> after 4096 idle cycles Timeout=1, Done=1, Check_ok=0.
- Loop=1, Mode 2 -> Pass_cnt reaches 3 without a new Start. Rst_n pulsed low mid-WRITE -> all outputs 0 immediately and App_wr_en=0.
- Sdr_init_done=0 for 100 cycles after Start, and Sdr_init_ref_vld pulsed during READ -> no requests while either is blocking, pass completes with Check_ok=1.
